// File: rtl/ga22_obj_fetch.sv
// ---------------------------------------------------------------------------
// ga22_obj_fetch
//
// Per-scanline sprite fetch engine feeding the sprite double line buffer.
// On line_start it walks every entry of object attribute RAM, clips each
// entry vertically against the requested scanline, fetches the matching
// 16-pixel row (64 bits of bitplanes) from sprite ROM for every hit, and
// hands that row to the line buffer as a single write strobe once the
// buffer reports idle.
//
// Optional feature: define GA22_OBJ_LIMIT_EN to cap the number of hits per
// line at MAX_PER_LINE. When the cap is reached the walk ends early and
// overflow stays high until the next line_start. Without the macro every
// entry is processed and overflow is tied low.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   line_start/line_num start (or restart) a walk for scanline line_num
//   busy, done          walk in progress / one-cycle completion pulse
//   overflow            hit cap reached on the current line
//   obj_addr/obj_data   object RAM port, data valid one cycle after address
//   rom_req/rom_addr    sprite ROM request, held until rom_ack
//   rom_ack/rom_data    sprite ROM response
//   lb_idle             line buffer can accept a write
//   lb_*                registered draw write towards the line buffer
// ---------------------------------------------------------------------------
module ga22_obj_fetch #(
    parameter int OBJ_AW       = 8,
    parameter int MAX_PER_LINE = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              line_start,
    input  logic [8:0]        line_num,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [OBJ_AW-1:0] obj_addr,
    input  logic [63:0]       obj_data,
    output logic              rom_req,
    output logic [19:0]       rom_addr,
    input  logic              rom_ack,
    input  logic [63:0]       rom_data,
    input  logic              lb_idle,
    output logic [63:0]       lb_bitplanes,
    output logic              lb_flip,
    output logic [6:0]        lb_color,
    output logic              lb_prio,
    output logic [9:0]        lb_pos,
    output logic              lb_we
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_FETCH,
        S_WAIT_LB,
        S_ISSUE,
        S_NEXT
    } state_t;

    state_t            state_q, state_d;
    logic [8:0]        line_q, line_d;
    logic [OBJ_AW-1:0] obj_addr_q, obj_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              rom_req_q, rom_req_d;
    logic [19:0]       rom_addr_q, rom_addr_d;
    logic [63:0]       row_data_q, row_data_d;
    logic              att_flip_q, att_flip_d;
    logic [6:0]        att_color_q, att_color_d;
    logic              att_prio_q, att_prio_d;
    logic [9:0]        att_pos_q, att_pos_d;
    logic [63:0]       lb_bp_q, lb_bp_d;
    logic              lb_flip_q, lb_flip_d;
    logic [6:0]        lb_color_q, lb_color_d;
    logic              lb_prio_q, lb_prio_d;
    logic [9:0]        lb_pos_q, lb_pos_d;
    logic              lb_we_q, lb_we_d;
`ifdef GA22_OBJ_LIMIT_EN
    logic [5:0]        hit_cnt_q, hit_cnt_d;
`endif

    // Vertical clip. The 9-bit subtraction wraps naturally, so a sprite
    // straddling line 511 -> 0 still yields the right row. The row is only
    // meaningful when hit is set (row < 128), so its low 7 bits suffice for
    // the flip arithmetic.
    logic [8:0]  row;
    logic [7:0]  height;
    logic        hit;
    logic [7:0]  r_full;
    logic [15:0] tile_code;

    assign row       = line_q - obj_data[8:0];
    assign height    = 8'd16 << obj_data[10:9];
    assign hit       = row < {1'b0, height};
    assign r_full    = obj_data[41] ? (height - 8'd1 - row[7:0]) : row[7:0];
    assign tile_code = obj_data[31:16] + {13'd0, r_full[6:4]};

    logic unused_bits;
    assign unused_bits = ^{obj_data[15:11], obj_data[47:42], obj_data[63:58], r_full[7]};

`ifndef GA22_OBJ_LIMIT_EN
    logic unused_cfg;
    assign unused_cfg = (MAX_PER_LINE == 0);
`endif

    // State and datapath registers. Every register resets to zero so that a
    // mid-walk reset drops any pending request or write immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            line_q      <= '0;
            obj_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            rom_req_q   <= 1'b0;
            rom_addr_q  <= '0;
            row_data_q  <= '0;
            att_flip_q  <= 1'b0;
            att_color_q <= '0;
            att_prio_q  <= 1'b0;
            att_pos_q   <= '0;
            lb_bp_q     <= '0;
            lb_flip_q   <= 1'b0;
            lb_color_q  <= '0;
            lb_prio_q   <= 1'b0;
            lb_pos_q    <= '0;
            lb_we_q     <= 1'b0;
`ifdef GA22_OBJ_LIMIT_EN
            hit_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            obj_addr_q  <= obj_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            rom_req_q   <= rom_req_d;
            rom_addr_q  <= rom_addr_d;
            row_data_q  <= row_data_d;
            att_flip_q  <= att_flip_d;
            att_color_q <= att_color_d;
            att_prio_q  <= att_prio_d;
            att_pos_q   <= att_pos_d;
            lb_bp_q     <= lb_bp_d;
            lb_flip_q   <= lb_flip_d;
            lb_color_q  <= lb_color_d;
            lb_prio_q   <= lb_prio_d;
            lb_pos_q    <= lb_pos_d;
            lb_we_q     <= lb_we_d;
`ifdef GA22_OBJ_LIMIT_EN
            hit_cnt_q   <= hit_cnt_d;
`endif
        end
    end

    // Next-state logic. line_start takes priority in every state, which
    // gives both the normal start from IDLE and the abort-and-restart while
    // busy. Aborting drops rom_req; since acks are only honoured in FETCH,
    // a late ack for the abandoned request is simply ignored. The attribute
    // latches stay separate from the lb_* registers so the line buffer sees
    // stable data between strobes.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        obj_addr_d  = obj_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        rom_req_d   = rom_req_q;
        rom_addr_d  = rom_addr_q;
        row_data_d  = row_data_q;
        att_flip_d  = att_flip_q;
        att_color_d = att_color_q;
        att_prio_d  = att_prio_q;
        att_pos_d   = att_pos_q;
        lb_bp_d     = lb_bp_q;
        lb_flip_d   = lb_flip_q;
        lb_color_d  = lb_color_q;
        lb_prio_d   = lb_prio_q;
        lb_pos_d    = lb_pos_q;
        lb_we_d     = 1'b0;
`ifdef GA22_OBJ_LIMIT_EN
        hit_cnt_d   = hit_cnt_q;
`endif

        if (line_start) begin
            line_d     = line_num;
            obj_addr_d = '0;
            overflow_d = 1'b0;
            busy_d     = 1'b1;
            rom_req_d  = 1'b0;
            state_d    = S_READ;
`ifdef GA22_OBJ_LIMIT_EN
            hit_cnt_d  = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_READ: state_d = S_CHECK;
                S_CHECK: begin
                    if (hit) begin
                        rom_addr_d  = {tile_code, r_full[3:0]};
                        att_flip_d  = obj_data[40];
                        att_color_d = obj_data[38:32];
                        att_prio_d  = obj_data[39];
                        att_pos_d   = obj_data[57:48];
                        rom_req_d   = 1'b1;
                        state_d     = S_FETCH;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
                S_FETCH: begin
                    if (rom_ack) begin
                        row_data_d = rom_data;
                        rom_req_d  = 1'b0;
                        state_d    = S_WAIT_LB;
                    end
                end
                S_WAIT_LB: begin
                    if (lb_idle) begin
                        lb_bp_d    = row_data_q;
                        lb_flip_d  = att_flip_q;
                        lb_color_d = att_color_q;
                        lb_prio_d  = att_prio_q;
                        lb_pos_d   = att_pos_q;
                        lb_we_d    = 1'b1;
                        state_d    = S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef GA22_OBJ_LIMIT_EN
                    hit_cnt_d = hit_cnt_q + 6'd1;
                    if (hit_cnt_q == 6'(MAX_PER_LINE - 1)) begin
                        overflow_d = 1'b1;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_NEXT;
                    end
`else
                    state_d = S_NEXT;
`endif
                end
                S_NEXT: begin
                    if (obj_addr_q == {OBJ_AW{1'b1}}) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        obj_addr_d = obj_addr_q + OBJ_AW'(1);
                        state_d    = S_READ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign obj_addr     = obj_addr_q;
    assign rom_req      = rom_req_q;
    assign rom_addr     = rom_addr_q;
    assign lb_bitplanes = lb_bp_q;
    assign lb_flip      = lb_flip_q;
    assign lb_color     = lb_color_q;
    assign lb_prio      = lb_prio_q;
    assign lb_pos       = lb_pos_q;
    assign lb_we        = lb_we_q;

endmodule

// File: tb/tb_ga22_obj_fetch.sv
// ---------------------------------------------------------------------------
// tb_ga22_obj_fetch
//
// Scoreboard bench for ga22_obj_fetch. Starting a line runs a reference
// model over the object RAM image and queues the expected ROM addresses,
// line buffer writes and done/overflow outcome; a monitor pops and compares
// whenever the DUT raises rom_req, lb_we or done. Object RAM, sprite ROM
// (random latency) and line buffer idle are behavioural responders.
// ---------------------------------------------------------------------------
module tb_ga22_obj_fetch;

    localparam int OBJ_AW       = 8;
    localparam int NUM_OBJ      = 1 << OBJ_AW;
    localparam int MAX_PER_LINE = 32;
`ifdef GA22_OBJ_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic              line_start;
    logic [8:0]        line_num;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [OBJ_AW-1:0] obj_addr;
    logic [63:0]       obj_data;
    logic              rom_req;
    logic [19:0]       rom_addr;
    logic              rom_ack;
    logic [63:0]       rom_data;
    logic              lb_idle;
    logic [63:0]       lb_bitplanes;
    logic              lb_flip;
    logic [6:0]        lb_color;
    logic              lb_prio;
    logic [9:0]        lb_pos;
    logic              lb_we;

    ga22_obj_fetch #(.OBJ_AW(OBJ_AW), .MAX_PER_LINE(MAX_PER_LINE)) dut (
        .clk(clk), .reset_n(reset_n), .line_start(line_start), .line_num(line_num),
        .busy(busy), .done(done), .overflow(overflow),
        .obj_addr(obj_addr), .obj_data(obj_data),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .lb_idle(lb_idle), .lb_bitplanes(lb_bitplanes), .lb_flip(lb_flip),
        .lb_color(lb_color), .lb_prio(lb_prio), .lb_pos(lb_pos), .lb_we(lb_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] bp;
        logic        flip;
        logic [6:0]  color;
        logic        prio;
        logic [9:0]  pos;
    } lb_t;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] obj_mem [NUM_OBJ];
    logic [19:0] exp_rom [$];
    lb_t         exp_lb [$];
    bit          exp_done [$];

    bit          rom_auto      = 1'b1;
    int          rom_lat_fixed = 0;
    logic [63:0] rom_override  = '0;
    int          stray_req     = 0;
    int          stray_done    = 0;
    int          lb_mode       = 0;
    int          rom_req_count = 0;
    int          rom_ack_count = 0;
    int          lb_we_count   = 0;
    int          done_count    = 0;
    logic [19:0] last_rom_addr = '0;

    // Sprite ROM contents as seen by both the responder and the model.
    function automatic logic [63:0] rom_model(input logic [19:0] a);
        if (rom_override != 64'd0) return rom_override;
        return {12'hA5A, a, 12'h5A5, ~a};
    endfunction

    function automatic logic [63:0] mk_obj(input int y, input int h, input int code,
                                           input int color, input int prio,
                                           input int flipx, input int flipy, input int x);
        logic [63:0] e;
        e = '0;
        e[8:0]   = y[8:0];
        e[10:9]  = h[1:0];
        e[31:16] = code[15:0];
        e[38:32] = color[6:0];
        e[39]    = prio[0];
        e[40]    = flipx[0];
        e[41]    = flipy[0];
        e[57:48] = x[9:0];
        return e;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic fill_default();
        for (int i = 0; i < NUM_OBJ; i++) obj_mem[i] = mk_obj(300, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NUM_OBJ; i++)
            obj_mem[i] = mk_obj($urandom_range(0, 511), $urandom_range(0, 3), $urandom,
                                $urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    // Reference model: for every entry, compute how far the line lies below
    // the sprite top (mod 512) and, if inside the sprite, which row of which
    // 16-line tile is needed.
    task automatic push_line(input int line);
        int hits;
        bit ovf;
        hits = 0;
        ovf  = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            logic [63:0] e;
            int y, hgt, row, r, a;
            lb_t w;
            e   = obj_mem[i];
            y   = int'(e[8:0]);
            hgt = 16 << int'(e[10:9]);
            row = (line - y + 512) % 512;
            if (row < hgt) begin
                r = e[41] ? (hgt - 1 - row) : row;
                a = ((int'(e[31:16]) + r / 16) % 65536) * 16 + r % 16;
                exp_rom.push_back(a[19:0]);
                w.bp    = rom_model(a[19:0]);
                w.flip  = e[40];
                w.color = e[38:32];
                w.prio  = e[39];
                w.pos   = e[57:48];
                exp_lb.push_back(w);
                hits++;
                if (LIMIT_ON && hits == MAX_PER_LINE) begin
                    ovf = 1'b1;
                    break;
                end
            end
        end
        exp_done.push_back(ovf);
    endtask

    task automatic apply_stimulus(input int line);
        @(negedge clk);
        push_line(line);
        line_num   = line[8:0];
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start, n;
        start = done_count;
        n = 0;
        while (done_count == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("done_seen", done_count != start, 1);
    endtask

    task automatic flush_expect();
        exp_rom.delete();
        exp_lb.delete();
        exp_done.delete();
    endtask

    // Object RAM: address sampled during a cycle, data presented after the
    // following rising edge.
    initial begin
        logic [OBJ_AW-1:0] raddr;
        obj_data = '0;
        forever begin
            @(negedge clk);
            raddr = obj_addr;
            @(posedge clk);
            #1 obj_data = obj_mem[raddr];
        end
    end

    // Sprite ROM responder with per-request latency; can also inject a
    // stray ack on request of the stimulus.
    initial begin
        int cnt, lat;
        cnt = 0;
        lat = 1;
        rom_ack  = 1'b0;
        rom_data = '0;
        forever begin
            @(negedge clk);
            if (stray_req != stray_done) begin
                rom_ack  = 1'b1;
                rom_data = 64'hBAD0BAD0BAD0BAD0;
                stray_done++;
                cnt = 0;
            end else if (rom_ack) begin
                rom_ack = 1'b0;
                cnt = 0;
            end else if (rom_req && rom_auto && reset_n) begin
                if (cnt == 0) lat = (rom_lat_fixed > 0) ? rom_lat_fixed : $urandom_range(1, 4);
                cnt++;
                if (cnt >= lat) begin
                    rom_ack  = 1'b1;
                    rom_data = rom_model(rom_addr);
                    rom_ack_count++;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Line buffer idle driver: 0 always idle, 1 random, 2 held busy.
    initial begin
        lb_idle = 1'b1;
        forever begin
            @(negedge clk);
            case (lb_mode)
                0:       lb_idle = 1'b1;
                1:       lb_idle = ($urandom_range(0, 3) != 0);
                default: lb_idle = 1'b0;
            endcase
        end
    end

    // Monitor: compares every DUT transaction against the scoreboard.
    initial begin
        bit          prev_req;
        logic [19:0] cur_addr;
        lb_t         w;
        bit          ov;
        prev_req = 1'b0;
        cur_addr = '0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (rom_req && !prev_req) begin
                    rom_req_count++;
                    last_rom_addr = rom_addr;
                    check_output("rom_req_expected", exp_rom.size() > 0, 1);
                    if (exp_rom.size() > 0) begin
                        cur_addr = exp_rom.pop_front();
                        check_output("rom_addr", rom_addr, cur_addr);
                    end
                end else if (rom_req) begin
                    check_output("rom_addr_stable", rom_addr, cur_addr);
                end
                if (lb_we) begin
                    lb_we_count++;
                    check_output("lb_we_expected", exp_lb.size() > 0, 1);
                    if (exp_lb.size() > 0) begin
                        w = exp_lb.pop_front();
                        check_output("lb_bitplanes", lb_bitplanes, w.bp);
                        check_output("lb_flip", lb_flip, w.flip);
                        check_output("lb_color", lb_color, w.color);
                        check_output("lb_prio", lb_prio, w.prio);
                        check_output("lb_pos", lb_pos, w.pos);
                    end
                end
                if (done) begin
                    done_count++;
                    check_output("done_expected", exp_done.size() > 0, 1);
                    if (exp_done.size() > 0) begin
                        ov = exp_done.pop_front();
                        check_output("done_overflow", overflow, ov);
                    end
                    check_output("done_lb_drained", exp_lb.size(), 0);
                    check_output("done_rom_drained", exp_rom.size(), 0);
                    check_output("done_busy_low", busy, 0);
                end
            end
            prev_req = rom_req;
        end
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0, l0, n, line;
        reset_n    = 1'b0;
        line_start = 1'b0;
        line_num   = '0;
        fill_default();

        // Reset values
        repeat (3) @(negedge clk);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_overflow", overflow, 0);
        check_output("reset_rom_req", rom_req, 0);
        check_output("reset_lb_we", lb_we, 0);
        check_output("reset_obj_addr", obj_addr, 0);
        check_output("reset_rom_addr", rom_addr, 0);
        check_output("reset_lb_bitplanes", lb_bitplanes, 0);
        check_output("reset_lb_pos", lb_pos, 0);
        reset_n = 1'b1;

        // Single hit with a fixed 3-cycle ROM
        obj_mem[0]    = mk_obj(100, 0, 'h40, 5, 1, 0, 0, 200);
        rom_override  = 64'hDEADBEEF01234567;
        rom_lat_fixed = 3;
        l0 = lb_we_count;
        apply_stimulus(107);
        check_output("single_busy", busy, 1);
        wait_done(5000);
        check_output("single_rom_addr", last_rom_addr, 20'h00407);
        check_output("single_lb_count", lb_we_count - l0, 1);
        check_output("single_hold_bp", lb_bitplanes, 64'hDEADBEEF01234567);
        check_output("single_hold_pos", lb_pos, 200);
        check_output("single_hold_color", lb_color, 5);
        check_output("single_hold_prio", lb_prio, 1);
        rom_override  = '0;
        rom_lat_fixed = 0;

        // Tall flipped sprite
        obj_mem[0] = mk_obj(0, 2, 'h100, 9, 0, 1, 1, 33);
        apply_stimulus(5);
        wait_done(5000);
        check_output("tall_rom_addr", last_rom_addr, 20'h0103A);

        // Wrap across 511 -> 0, then a miss for the same entry
        obj_mem[0] = mk_obj(505, 0, 'h222, 3, 1, 0, 0, 500);
        c0 = rom_req_count;
        apply_stimulus(3);
        wait_done(5000);
        check_output("wrap_rom_addr", last_rom_addr, 20'h0222A);
        check_output("wrap_req_count", rom_req_count - c0, 1);
        c0 = rom_req_count;
        l0 = lb_we_count;
        apply_stimulus(16);
        wait_done(5000);
        check_output("wrap_miss_req", rom_req_count - c0, 0);
        check_output("wrap_miss_lb", lb_we_count - l0, 0);

        // Backpressure: line buffer busy for 20 cycles after the ack
        obj_mem[0] = mk_obj(100, 0, 'h40, 7, 0, 1, 0, 17);
        lb_mode = 2;
        c0 = rom_ack_count;
        l0 = lb_we_count;
        apply_stimulus(107);
        n = 0;
        while (rom_ack_count == c0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_output("bp_ack_seen", rom_ack_count != c0, 1);
        repeat (20) begin
            @(negedge clk);
            check_output("bp_we_low", lb_we, 0);
            check_output("bp_data_hold", lb_bitplanes, rom_model(20'h0222A));
            check_output("bp_pos_hold", lb_pos, 500);
        end
        lb_mode = 0;
        wait_done(5000);
        check_output("bp_lb_count", lb_we_count - l0, 1);

        // Abort during FETCH, then a stray ack
        fill_default();
        obj_mem[0] = mk_obj(100, 3, 'h40, 1, 0, 0, 0, 11);
        obj_mem[1] = mk_obj(5, 0, 'h77, 2, 0, 1, 0, 64);
        rom_auto = 1'b0;
        c0 = done_count;
        apply_stimulus(107);
        n = 0;
        while (!rom_req && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_output("abort_fetch_reached", rom_req, 1);
        repeat (3) @(negedge clk);
        flush_expect();
        push_line(10);
        line_num   = 9'd10;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        stray_req++;
        check_output("abort_obj_addr", obj_addr, 0);
        check_output("abort_rom_req", rom_req, 0);
        check_output("abort_busy", busy, 1);
        repeat (3) @(negedge clk);
        rom_auto = 1'b1;
        wait_done(5000);
        check_output("abort_done_count", done_count - c0, 1);
        check_output("abort_last_pos", lb_pos, 64);

        // Hit cap: 40 hitting entries
        fill_default();
        for (int i = 0; i < 40; i++) obj_mem[i] = mk_obj(50, 0, i * 4, i, i % 2, 0, 0, i * 5);
        lb_mode = 1;
        l0 = lb_we_count;
        apply_stimulus(55);
        wait_done(8000);
        check_output("limit_lb_count", lb_we_count - l0, LIMIT_ON ? 32 : 40);
        repeat (5) @(negedge clk);
        check_output("limit_overflow_hold", overflow, LIMIT_ON);

        // Randomized lines
        for (int t = 0; t < 8; t++) begin
            fill_random();
            line = $urandom_range(0, 511);
            apply_stimulus(line);
            check_output("rand_overflow_clear", overflow, 0);
            check_output("rand_busy", busy, 1);
            wait_done(8000);
        end

        // Reset in the middle of a walk
        fill_random();
        apply_stimulus($urandom_range(0, 511));
        repeat (60) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_output("midreset_busy", busy, 0);
        check_output("midreset_rom_req", rom_req, 0);
        check_output("midreset_lb_we", lb_we, 0);
        check_output("midreset_obj_addr", obj_addr, 0);
        check_output("midreset_lb_bitplanes", lb_bitplanes, 0);
        flush_expect();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_output("post_reset_lb_we", lb_we, 0);
        check_output("post_reset_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ga22_obj_fetch.md
Name: ga22_obj_fetch

Overview:
- Per-scanline sprite fetch engine; sits directly upstream of the sprite double line buffer.
- Walks object attribute RAM and vertically clips each entry against the requested line.
- Fetches one 16-pixel row (64-bit, two 4-plane groups of 8 pixels) per hit from sprite ROM.
- Issues one draw write per hit to the line buffer (bitplanes, flip, color, prio, pos, we), throttled by the buffer's idle flag.

Parameters:
- OBJ_AW, 8, object RAM entry address width; NUM_OBJ = 2**OBJ_AW entries.
- MAX_PER_LINE, 32, per-line hit cap (only with GA22_OBJ_LIMIT_EN).

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- line_start, in, 1, one-cycle pulse: begin list walk for line_num.
- line_num, in, 9, scanline being prepared.
- busy, out, 1, high from line_start until done.
- done, out, 1, one-cycle pulse when the walk completes.
- overflow, out, 1, hit cap reached on the current line (GA22_OBJ_LIMIT_EN only, else tied 0).
- obj_addr, out, OBJ_AW, object RAM read address.
- obj_data, in, 64, entry. Field layout:
  - [8:0] y; [10:9] h, height = 16<<h lines.
  - [31:16] code.
  - [38:32] color; [39] prio; [40] flipx; [41] flipy.
  - [57:48] x.
  - Valid one cycle after obj_addr.
- rom_req, out, 1, ROM request; held high until acked.
- rom_addr, out, 20, {code + tile, pixel_row[3:0]}.
- rom_ack, in, 1, rom_data valid this cycle.
- rom_data, in, 64, row bitplanes.
- lb_idle, in, 1, line buffer ready for a write.
- lb_bitplanes, out, 64, row data.
- lb_flip, out, 1, flipx.
- lb_color, out, 7, palette.
- lb_prio, out, 1, priority.
- lb_pos, out, 10, x.
- lb_we, out, 1, one-cycle write strobe.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE.
  - busy, done, overflow, rom_req, lb_we = 0.
  - obj_addr, rom_addr, lb_* data = 0.
- FSM states: IDLE, READ, CHECK, FETCH, WAIT_LB, ISSUE, NEXT.
  - IDLE: on line_start, latch line_num, set obj_addr = 0, clear overflow, busy = 1, go to READ.
  - READ: one wait cycle for RAM latency, then CHECK.
  - CHECK: compute row = (line − y) mod 512, 9-bit wrap, and H = 16<<h.
    - Hit iff row < H. On miss, go to NEXT.
    - On hit: r = flipy ? H−1−row : row; tile = r[6:4]; rom_addr = {code + tile (16-bit wrap), r[3:0]}; latch attributes; rom_req = 1; go to FETCH.
  - FETCH: hold rom_req and rom_addr stable until rom_ack.
    - On ack: capture rom_data, drop rom_req the same cycle, go to WAIT_LB.
  - WAIT_LB: when lb_idle = 1, go to ISSUE.
  - ISSUE: drive lb_we = 1 for exactly one cycle with latched data; go to NEXT.
  - NEXT:
    - If obj_addr = NUM_OBJ−1: pulse done, busy = 0, go to IDLE.
    - Otherwise obj_addr + 1, go to READ.
- lb_* data outputs are registered and hold their values between strobes.
- Worst case per hit: 5 cycles plus ROM latency plus lb_idle wait.
- line_start while busy: abort the walk.
  - Drop rom_req; any ROM ack still outstanding is ignored.
  - Restart from entry 0 with the new line. No done pulse for the aborted line.
- rom_ack outside FETCH is ignored.
- reset_n asserted mid-walk: immediate return to reset values; no partial lb_we.
- Hit whose row straddles the 511→0 wrap (e.g. y = 505, h = 0, line = 3) is a hit (row 10).

Optional Feature:
- GA22_OBJ_LIMIT_EN defined: hit counter (6 bits), cleared on line_start.
  - After the MAX_PER_LINE-th ISSUE, set overflow = 1, skip all remaining entries, pulse done, and return to IDLE.
  - overflow holds until the next line_start.
- GA22_OBJ_LIMIT_EN not defined: no counter; all NUM_OBJ entries processed; overflow constant 0.

Test Plan:
- Single hit: entry 0 with y = 100, h = 0, code = 0x0040, x = 200, color = 5, prio = 1; other entries y = 300; line 107; ROM acks after 3 cycles with 0xDEADBEEF01234567.
  - rom_addr = 0x00407; one lb_we with pos = 200, color = 5, prio = 1, bitplanes = 0xDEADBEEF01234567.
  - done after the full walk.
- Tall flipped: y = 0, h = 2 (64 lines), flipy = 1, code = 0x0100, line 5 → r = 58, tile 3; rom_addr = 0x0103A.
- Wrap: y = 505, h = 0, line 3 → hit, row 10; same entry at line 16 → miss, no rom_req.
- Backpressure: hold lb_idle = 0 for 20 cycles after ack.
  - lb_we stays 0 and lb data stays stable; exactly one lb_we after lb_idle rises.
- Abort: line_start(10) during FETCH, then rom_ack asserted.
  - Ack ignored; walk restarts at obj_addr 0; exactly one done, for line 10.
- Limit (GA22_OBJ_LIMIT_EN, MAX_PER_LINE = 32): 40 hitting entries.
  - Exactly 32 lb_we, then overflow = 1 and done; without the macro, 40 lb_we and overflow = 0.
